regfile_write_arbiter: RTL and testbench

//  Shares the register file's single write port (we/addr3/wd) between two writeback

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_write_arbiter_rr_arb2.sv | 38 +++
 rtl/regfile_write_arbiter.sv | 90 +++++++++
 tb/tb_regfile_write_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the register-file write arbiter: port widths and the
// request index used by the 2-way round-robin grant vector.
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 2 ** ADDR_W;

  // Bit positions inside the req/gnt vectors of rr_arb2.
  localparam int REQ_MEM = 0;
  localparam int REQ_ALU = 1;

endpackage

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a lone request is granted, and on contention the
// requester that did not win the previous grant goes first.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  import regfile_pkg::REQ_MEM;
  import regfile_pkg::REQ_ALU;

  // 1 when the ALU side received the most recent grant; reset makes mem go first.
  logic last_alu_q;

  always_comb begin
    gnt = '0;
    unique case (req)
      2'b01:   gnt[REQ_MEM] = 1'b1;
      2'b10:   gnt[REQ_ALU] = 1'b1;
      2'b11: begin
        if (last_alu_q) gnt[REQ_MEM] = 1'b1;
        else            gnt[REQ_ALU] = 1'b1;
      end
      default: gnt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_alu_q <= 1'b1;
    end else if (gnt[REQ_MEM]) begin
      last_alu_q <= 1'b0;
    end else if (gnt[REQ_ALU]) begin
      last_alu_q <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between the ALU and load writeback paths
// and tracks a per-register pending-write scoreboard for the issue stage.
module regfile_write_arbiter #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  input  logic [ADDR_W-1:0]      alu_addr,
  input  logic [DATA_W-1:0]      alu_data,
  output logic                   alu_ready,
  input  logic                   mem_valid,
  input  logic [ADDR_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      mem_data,
  output logic                   mem_ready,
  input  logic                   claim_valid,
  input  logic [ADDR_W-1:0]      claim_addr,
  output logic [2**ADDR_W-1:0]   busy,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_addr,
  output logic [DATA_W-1:0]      rf_wd
);
  import regfile_pkg::REQ_MEM;
  import regfile_pkg::REQ_ALU;

  localparam int NUM_REGS = 2 ** ADDR_W;

  // Handshake: a request transfers on a cycle where valid && ready. While
  // valid && !ready the requester must keep valid, addr and data unchanged.
  // ready is combinational from valid/addr and the arbiter pointer only.
  logic                alu_x0, mem_x0;
  logic [1:0]          req, gnt;
  logic                grant_any;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;
  logic [NUM_REGS-1:0] busy_next;

  // Writes to x0 are absorbed immediately and never compete for the port.
  assign alu_x0 = alu_valid && (alu_addr == '0);
  assign mem_x0 = mem_valid && (mem_addr == '0);

  assign req[REQ_ALU] = !rst && alu_valid && !alu_x0;
  assign req[REQ_MEM] = !rst && mem_valid && !mem_x0;

  rr_arb2 u_rr_arb2 (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  assign alu_ready = !rst && (alu_x0 || gnt[REQ_ALU]);
  assign mem_ready = !rst && (mem_x0 || gnt[REQ_MEM]);

  assign grant_any = |gnt;
  assign win_addr  = gnt[REQ_ALU] ? alu_addr : mem_addr;
  assign win_data  = gnt[REQ_ALU] ? alu_data : mem_data;

  // A claim landing on the same edge as a clear marks a newer producer, so set wins.
  always_comb begin
    busy_next = busy;
    if (grant_any) busy_next[win_addr] = 1'b0;
    if (claim_valid && (claim_addr != '0)) busy_next[claim_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we   <= 1'b0;
      rf_addr <= '0;
      rf_wd   <= '0;
      busy    <= '0;
    end else begin
      rf_we <= grant_any;
      if (grant_any) begin
        rf_addr <= win_addr;
        rf_wd   <= win_data;
      end
      busy <= busy_next;
    end
  end

  alu_hold_a : assert property (@(posedge clk) disable iff (rst)
    (alu_valid && !alu_ready) |=> (alu_valid && $stable(alu_addr) && $stable(alu_data)));

  mem_hold_a : assert property (@(posedge clk) disable iff (rst)
    (mem_valid && !mem_ready) |=> (mem_valid && $stable(mem_addr) && $stable(mem_data)));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and randomized bench for regfile_write_arbiter with a register-level
// reference model of arbitration, write latency and the busy scoreboard.
module tb_regfile_write_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alu_valid = 1'b0;
  logic [AW-1:0] alu_addr  = '0;
  logic [DW-1:0] alu_data  = '0;
  logic          alu_ready;
  logic          mem_valid = 1'b0;
  logic [AW-1:0] mem_addr  = '0;
  logic [DW-1:0] mem_data  = '0;
  logic          mem_ready;
  logic          claim_valid = 1'b0;
  logic [AW-1:0] claim_addr  = '0;
  logic [NR-1:0] busy;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_wd;

  regfile_write_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_addr    (alu_addr),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .busy        (busy),
    .rf_we       (rf_we),
    .rf_addr     (rf_addr),
    .rf_wd       (rf_wd)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model state
  int                  checks   = 0;
  int                  failures = 0;
  logic                m_last_alu = 1'b1;
  logic [NR-1:0]       m_busy = '0;
  logic [DW-1:0]       m_rf  [NR];
  logic [DW-1:0]       tb_rf [NR];
  logic [AW+DW-1:0]    exp_q [$];
  logic                exp_alu_rdy = 1'b0;
  logic                exp_mem_rdy = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver: applies one cycle of inputs, checks ready, then the registered results
  task automatic drive(input logic r,
                       input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                       input logic cv, input logic [AW-1:0] ca);
    logic             a_real, m_real, w_alu, w_mem, e_ar, e_mr;
    logic [AW+DW-1:0] wr;
    @(negedge clk);
    rst = r; alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    claim_valid = cv; claim_addr = ca;
    a_real = av && (aa != 0);
    m_real = mv && (ma != 0);
    w_alu = 1'b0; w_mem = 1'b0;
    if (!r) begin
      if (a_real && m_real) begin
        if (m_last_alu) w_mem = 1'b1;
        else            w_alu = 1'b1;
      end else begin
        w_alu = a_real;
        w_mem = m_real;
      end
    end
    e_ar = !r && ((av && aa == 0) || w_alu);
    e_mr = !r && ((mv && ma == 0) || w_mem);
    #1;
    check("alu_ready", 64'(alu_ready), 64'(e_ar));
    check("mem_ready", 64'(mem_ready), 64'(e_mr));
    exp_alu_rdy = e_ar;
    exp_mem_rdy = e_mr;
    if (r) begin
      m_busy = '0;
      m_last_alu = 1'b1;
    end else begin
      if (w_alu) begin
        exp_q.push_back({aa, ad});
        m_rf[aa] = ad; m_busy[aa] = 1'b0; m_last_alu = 1'b1;
      end else if (w_mem) begin
        exp_q.push_back({ma, md});
        m_rf[ma] = md; m_busy[ma] = 1'b0; m_last_alu = 1'b0;
      end
      if (cv && ca != 0) m_busy[ca] = 1'b1;
    end
    @(posedge clk);
    #1;
    if (w_alu || w_mem) begin
      wr = exp_q.pop_front();
      check("rf_we", 64'(rf_we), 64'd1);
      check("rf_addr", 64'(rf_addr), 64'(wr[AW+DW-1:DW]));
      check("rf_wd", 64'(rf_wd), 64'(wr[DW-1:0]));
    end else begin
      check("rf_we_idle", 64'(rf_we), 64'd0);
    end
    if (r) begin
      check("rst_rf_addr", 64'(rf_addr), 64'd0);
      check("rst_rf_wd", 64'(rf_wd), 64'd0);
    end
    check("busy", 64'(busy), 64'(m_busy));
    if (rf_we) tb_rf[rf_addr] = rf_wd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  logic          pa_v, pm_v, pc_v, pr;
  logic [AW-1:0] pa_a, pm_a, pc_a;
  logic [DW-1:0] pa_d, pm_d;

  initial begin
    for (int i = 0; i < NR; i++) begin
      m_rf[i]  = '0;
      tb_rf[i] = '0;
    end
    do_reset();
    do_reset();

    // ALU alone: ready now, write next cycle, then port idle
    drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, '0);
    idle();

    // contention after reset: mem first, then alu, then mem's repeat request
    do_reset();
    drive(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, '0);
    drive(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, '0);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd4, 32'h22, 1'b0, '0);
    idle();
    check("x4_value", 64'(tb_rf[4]), 64'h22);
    check("x3_value", 64'(tb_rf[3]), 64'h11);

    // x0 request alongside a real one: both accepted, only x7 written
    drive(1'b0, 1'b1, 5'd0, 32'h55, 1'b1, 5'd7, 32'h77, 1'b0, '0);
    idle();
    check("x0_value", 64'(tb_rf[0]), 64'h0);

    // scoreboard: claim, grant+reclaim keeps busy, plain grant clears
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9);
    check("busy9_kept", 64'(busy[9]), 64'd1);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd9, 32'h9A, 1'b0, '0);
    check("busy9_cleared", 64'(busy[9]), 64'd0);
    idle();

    // same destination from both: mem then alu, alu value is final
    do_reset();
    drive(1'b0, 1'b1, 5'd6, 32'hA, 1'b1, 5'd6, 32'hB, 1'b0, '0);
    drive(1'b0, 1'b1, 5'd6, 32'hA, 1'b0, '0, '0, 1'b0, '0);
    idle();
    check("x6_final", 64'(tb_rf[6]), 64'hA);

    // reset in the middle of contention with pending busy bits
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd12);
    drive(1'b0, 1'b1, 5'd1, 32'h1111, 1'b1, 5'd2, 32'h2222, 1'b1, 5'd13);
    drive(1'b1, 1'b1, 5'd1, 32'h1111, 1'b1, 5'd2, 32'h2222, 1'b0, '0);
    drive(1'b0, 1'b1, 5'd1, 32'h1111, 1'b1, 5'd2, 32'h2222, 1'b0, '0);
    drive(1'b0, 1'b1, 5'd1, 32'h1111, 1'b0, '0, '0, 1'b0, '0);
    idle();

    // randomized traffic; pending requests are held until accepted
    pa_v = 1'b0; pm_v = 1'b0; pa_a = '0; pm_a = '0; pa_d = '0; pm_d = '0;
    exp_alu_rdy = 1'b0; exp_mem_rdy = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!(pa_v && !exp_alu_rdy)) begin
        pa_v = ($urandom_range(0, 3) != 0);
        pa_a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NR - 1)) : AW'($urandom_range(0, 7));
        pa_d = $urandom;
      end
      if (!(pm_v && !exp_mem_rdy)) begin
        pm_v = ($urandom_range(0, 3) != 0);
        pm_a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NR - 1)) : AW'($urandom_range(0, 7));
        pm_d = $urandom;
      end
      pc_v = ($urandom_range(0, 1) == 1);
      pc_a = AW'($urandom_range(0, 9));
      pr   = ($urandom_range(0, 63) == 0);
      drive(pr, pa_v, pa_a, pa_d, pm_v, pm_a, pm_d, pc_v, pc_a);
    end
    pa_v = pa_v && !exp_alu_rdy;
    pm_v = pm_v && !exp_mem_rdy;
    for (int n = 0; n < 3; n++) begin
      drive(1'b0, pa_v, pa_a, pa_d, pm_v, pm_a, pm_d, 1'b0, '0);
      pa_v = pa_v && !exp_alu_rdy;
      pm_v = pm_v && !exp_mem_rdy;
    end
    idle();

    // scoreboard: register contents seen on the write port vs. the model
    for (int i = 0; i < NR; i++) begin
      check($sformatf("rf_x%0d", i), 64'(tb_rf[i]), 64'(m_rf[i]));
    end
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
